// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the memory stage (master) and the memory system (slave):
// request/grant handshake followed by a read-valid response.
interface mem_access_unit_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: issues load/store transactions on the req/gnt/rvalid data bus, stalls the core
// while they are in flight, and aligns/extends load data for write-back.
module mem_access_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    output logic [31:0] mem_out,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err,
    mem_access_unit_if.master dbus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_GNT = 2'd1,
        S_WAIT_RD  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_mem_out;

    logic        w_access;
    logic        w_f3_ok;
    logic        w_align_ok;
    logic        w_legal;
    logic        w_start;
    logic        w_timeout;
    logic        w_abort;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load;

    assign w_access  = mem_read | mem_write;
    assign w_timeout = (r_cnt == TIMEOUT_LAST);

    // Unsigned loads (BU/HU) have no store counterpart, so they are illegal with mem_write.
    always_comb begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b0;
        case (funct3)
            3'b000: begin w_f3_ok = 1'b1;       w_align_ok = 1'b1;                end
            3'b001: begin w_f3_ok = 1'b1;       w_align_ok = ~alu_out[0];         end
            3'b010: begin w_f3_ok = 1'b1;       w_align_ok = (alu_out[1:0] == 2'b00); end
            3'b100: begin w_f3_ok = ~mem_write; w_align_ok = 1'b1;                end
            3'b101: begin w_f3_ok = ~mem_write; w_align_ok = ~alu_out[0];         end
            default: begin w_f3_ok = 1'b0;      w_align_ok = 1'b0;                end
        endcase
    end

    assign w_legal = w_f3_ok & w_align_ok;
    assign w_start = (r_state == S_IDLE) & w_access & w_legal;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_out[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << alu_out[1:0];
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    assign w_lane = dbus.dbus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = w_lane;
        case (r_funct3)
            3'b000:  w_load = {{24{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b101:  w_load = {16'd0, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    // State register plus the access latch, timeout counter and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_be      <= 4'd0;
            r_wdata   <= 32'd0;
            r_funct3  <= 3'd0;
            r_off     <= 2'd0;
            r_mem_out <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state)
                r_cnt <= 8'd0;
            else if (r_state == S_WAIT_GNT || r_state == S_WAIT_RD)
                r_cnt <= r_cnt + 8'd1;
            if (w_start) begin
                r_we     <= mem_write;
                r_addr   <= {alu_out[31:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= w_wdata;
                r_funct3 <= funct3;
                r_off    <= alu_out[1:0];
            end
            if (r_state == S_WAIT_RD && dbus.dbus_rvalid)
                r_mem_out <= w_load;
            else if (w_abort)
                r_mem_out <= 32'd0;
        end
    end

    // Grant/rvalid take priority over a timeout landing on the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start)
                    w_state_next = S_WAIT_GNT;
            end
            S_WAIT_GNT: begin
                if (dbus.dbus_gnt)
                    w_state_next = r_we ? S_DONE : S_WAIT_RD;
                else if (w_timeout)
                    w_state_next = S_DONE;
            end
            S_WAIT_RD: begin
                if (dbus.dbus_rvalid || w_timeout)
                    w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held, even if the core presents an access.
    always_comb begin
        stall        = 1'b0;
        misalign_err = 1'b0;
        w_abort      = 1'b0;
        dbus.dbus_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall        = rst_n & w_start;
                misalign_err = rst_n & w_access & ~w_legal;
            end
            S_WAIT_GNT: begin
                stall         = 1'b1;
                dbus.dbus_req = 1'b1;
                w_abort       = ~dbus.dbus_gnt & w_timeout;
            end
            S_WAIT_RD: begin
                stall   = 1'b1;
                w_abort = ~dbus.dbus_rvalid & w_timeout;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        bus_err = w_abort;
    end

    assign mem_out         = r_mem_out;
    assign dbus.dbus_we    = r_we;
    assign dbus.dbus_addr  = r_addr;
    assign dbus.dbus_be    = r_be;
    assign dbus.dbus_wdata = r_wdata;
endmodule
